// File: rtl/gray_window_arbiter.sv
// Shares one host gray-image read port among N_REQ LBP engines, issuing the 9 reads of a 3x3 window.
// Define GRAY_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module gray_window_arbiter #(
  parameter int N_REQ = 2,
  parameter int AW    = 14,
  parameter int DW    = 8,
  parameter int IMG_W = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gray_ready,
  output logic                gray_req,
  output logic [AW-1:0]       gray_addr,
  input  logic [DW-1:0]       gray_data,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [3:0]          rd_idx,
  output logic [DW-1:0]       rd_data,
  output logic [N_REQ-1:0]    win_done,
  output logic                busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW-1:0] ROW = AW'(IMG_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       beat_q, beat_d;
  logic [AW-1:0]    base_q, base_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] rd_valid_q, rd_valid_d;
  logic [3:0]       rd_idx_q, rd_idx_d;

  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic [AW-1:0]    offset;

`ifdef GRAY_ARB_FIXED_PRI_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  int            cand;

  // Circular search beginning at the round-robin pointer.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_idx   = cand[IW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && gray_ready && win_found) begin
      if (win_idx == IW'(N_REQ - 1)) rr_d = '0;
      else                           rr_d = win_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  // Window order: centre first, then the row above, same row, row below.
  always_comb begin
    case (beat_q)
      4'd1:    offset = AW'(0) - ROW - AW'(1);
      4'd2:    offset = AW'(0) - ROW;
      4'd3:    offset = AW'(0) - ROW + AW'(1);
      4'd4:    offset = AW'(0) - AW'(1);
      4'd5:    offset = AW'(1);
      4'd6:    offset = ROW - AW'(1);
      4'd7:    offset = ROW;
      4'd8:    offset = ROW + AW'(1);
      default: offset = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    grant_d    = grant_q;
    rd_valid_d = '0;
    rd_idx_d   = '0;
    case (state_q)
      IDLE: begin
        if (gray_ready && win_found) begin
          state_d = ISSUE;
          beat_d  = '0;
          base_d  = req_addr[win_idx*AW +: AW];
          grant_d = N_REQ'(1) << win_idx;
        end
      end
      ISSUE: begin
        rd_valid_d = grant_q;
        rd_idx_d   = beat_q;
        if (beat_q == 4'd8) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      grant_q    <= '0;
      rd_valid_q <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      grant_q    <= grant_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Host data arrives one cycle after its address, so it is forwarded combinationally.
  assign gray_req  = (state_q == ISSUE);
  assign gray_addr = (state_q == ISSUE) ? base_q + offset : '0;
  assign grant     = grant_q;
  assign rd_valid  = rd_valid_q;
  assign rd_idx    = rd_idx_q;
  assign rd_data   = (|rd_valid_q) ? gray_data : '0;
  assign win_done  = (state_q == DRAIN) ? grant_q : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_window_arbiter.sv
// Randomized bench for gray_window_arbiter: a window-schedule model checks every cycle,
// and directed sequences pin the model with literal address lists and grant orders.
module tb_gray_window_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int IMG_W = 128;

  logic                clk = 1'b0;
  logic                reset;
  logic                gray_ready;
  logic                gray_req;
  logic [AW-1:0]       gray_addr;
  logic [DW-1:0]       gray_data = '0;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    rd_valid;
  logic [3:0]          rd_idx;
  logic [DW-1:0]       rd_data;
  logic [N_REQ-1:0]    win_done;
  logic                busy;

  gray_window_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .IMG_W(IMG_W)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .req_valid(req_valid),
    .req_addr(req_addr), .grant(grant), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .rd_data(rd_data), .win_done(win_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Model state: which window is in flight and when it was decided.
  bit            m_active = 1'b0;
  int            m_T = 0;
  int            m_win = 0;
  int            m_rr = 0;
  logic [AW-1:0] m_base = '0;

  // Monitor records.
  logic [N_REQ-1:0] done_seen = '0;
  logic [N_REQ-1:0] prev_grant = '0;
  logic [AW-1:0]    cap_addr[$];
  int               cap_cyc[$];
  int               cap_idx[$];
  int               grant_log[$];
  int               grant_cyc[$];
  int               done_cyc = 0;

  int e_addr1[9] = '{129, 0, 1, 2, 128, 130, 256, 257, 258};
  int e_addr3[9] = '{0, 16255, 16256, 16257, 16383, 1, 127, 128, 129};
`ifdef GRAY_ARB_FIXED_PRI_EN
  int e_grants[4] = '{0, 0, 0, 0};
`else
  int e_grants[4] = '{0, 1, 0, 1};
`endif

  // Pixel content of the host image at a given address.
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return a[7:0] ^ {a[13:8], 2'b00} ^ 8'h5A;
  endfunction

  // Address of window element k around centre base, as row/column displacement.
  function automatic logic [AW-1:0] nb(input logic [AW-1:0] base, input int k);
    int dr[9];
    int dc[9];
    dr = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
    return AW'(int'(base) + dr[k] * IMG_W + dc[k]);
  endfunction

  function automatic int pickWinner(input logic [N_REQ-1:0] v, input int rr);
    int w;
    w = -1;
`ifdef GRAY_ARB_FIXED_PRI_EN
    for (int i = 0; i < N_REQ; i++)
      if (w < 0 && v[i]) w = i;
`else
    for (int i = 0; i < N_REQ; i++)
      if (w < 0 && v[(rr + i) % N_REQ]) w = (rr + i) % N_REQ;
`endif
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host: returns the pixel for the address presented on the previous cycle.
  always @(posedge clk) gray_data <= gray_req ? pix(gray_addr) : DW'($urandom);

  // Reference model: window decisions at each rising edge.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_active = 1'b0;
      m_rr     = 0;
    end else if (m_active) begin
      if (cyc == m_T + 10) m_active = 1'b0;
    end else if (gray_ready && |req_valid) begin
      m_win    = pickWinner(req_valid, m_rr);
      m_rr     = (m_win + 1) % N_REQ;
      m_base   = req_addr[m_win*AW +: AW];
      m_T      = cyc;
      m_active = 1'b1;
    end
    cyc++;
  end

  // Compare and monitor on the falling edge.
  initial forever begin
    int t;
    logic [N_REQ-1:0] oh;
    @(negedge clk);
    if (check_en) begin
      t  = cyc - m_T;
      oh = m_active ? N_REQ'(1) << m_win : '0;
      checkOutput("busy",     32'(busy),     32'(m_active));
      checkOutput("grant",    32'(grant),    32'(oh));
      checkOutput("gray_req", 32'(gray_req), 32'(m_active && t <= 9));
      checkOutput("gray_addr", 32'(gray_addr),
                  (m_active && t <= 9) ? 32'(nb(m_base, t - 1)) : 32'd0);
      checkOutput("rd_valid", 32'(rd_valid), (m_active && t >= 2) ? 32'(oh) : 32'd0);
      checkOutput("rd_idx",   32'(rd_idx),   (m_active && t >= 2) ? 32'(t - 2) : 32'd0);
      checkOutput("rd_data",  32'(rd_data),
                  (m_active && t >= 2) ? 32'(pix(nb(m_base, t - 2))) : 32'd0);
      checkOutput("win_done", 32'(win_done), (m_active && t == 10) ? 32'(oh) : 32'd0);
    end
    done_seen = done_seen | win_done;
    if (|win_done) done_cyc = cyc;
    if (gray_req) begin
      cap_addr.push_back(gray_addr);
      cap_cyc.push_back(cyc);
    end
    if (|rd_valid) cap_idx.push_back(int'(rd_idx));
    for (int i = 0; i < N_REQ; i++)
      if (grant[i] && !prev_grant[i]) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    prev_grant = grant;
  end

  task automatic clearCaptures();
    cap_addr.delete();
    cap_cyc.delete();
    cap_idx.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic waitDone(input int e, input string name);
    for (int k = 0; k < 40 && !done_seen[e]; k++) tick();
    n_cmp++;
    if (!done_seen[e]) begin
      n_fail++;
      $display("[TB] FAIL %s: win_done[%0d] not seen within 40 cycles", name, e);
    end
  endtask

  task automatic checkBurst(input string name, input int exp_addr[9]);
    checkOutput({name, "_len"}, 32'(cap_addr.size()), 32'd9);
    for (int k = 0; k < 9 && k < cap_addr.size(); k++)
      checkOutput({name, "_addr"}, 32'(cap_addr[k]), 32'(exp_addr[k]));
    for (int k = 0; k < 9 && k < cap_idx.size(); k++)
      checkOutput({name, "_idx"}, 32'(cap_idx[k]), 32'(k));
    if (cap_cyc.size() > 0)
      checkOutput({name, "_donelat"}, 32'(done_cyc - cap_cyc[0]), 32'd9);
  endtask

  task automatic applyStimulus();
    gray_ready = ($urandom_range(0, 3) != 0);
    reset      = ($urandom_range(0, 299) != 0);
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && done_seen[i]) begin
        req_valid[i] = 1'b0;
        done_seen[i] = 1'b0;
      end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = AW'($urandom);
      end
    end
    tick();
  endtask

  initial begin
    reset = 1'b0; gray_ready = 1'b0; req_valid = '0; req_addr = '0;
    tick();
    check_en = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("rst_gray_addr", 32'(gray_addr), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    reset = 1'b1;
    tick();

    // Centre 129 from engine 0.
    clearCaptures(); done_seen = '0;
    req_addr[0 +: AW] = AW'(129); req_valid = 2'b01; gray_ready = 1'b1;
    waitDone(0, "t1_done");
    req_valid = '0; done_seen = '0;
    repeat (3) tick();
    checkBurst("t1", e_addr1);

    // Centre 0 from engine 1 exercises wrap-around.
    clearCaptures();
    req_addr[AW +: AW] = '0; req_valid = 2'b10;
    waitDone(1, "t3_done");
    req_valid = '0; done_seen = '0;
    repeat (3) tick();
    checkBurst("t3", e_addr3);

    // Host not ready: nothing may start.
    gray_ready = 1'b0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    req_valid = 2'b11;
    req_addr = {AW'($urandom), AW'($urandom)};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4_gray_req", 32'(gray_req), 32'd0);
      checkOutput("t4_grant",    32'(grant),    32'd0);
      checkOutput("t4_busy",     32'(busy),     32'd0);
      tick();
    end

    // Both engines request continuously.
    clearCaptures(); done_seen = '0;
    gray_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      for (int i = 0; i < N_REQ; i++)
        if (done_seen[i]) begin
          done_seen[i] = 1'b0;
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      tick();
    end
    checkOutput("t2_ngrants", 32'(grant_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      checkOutput("t2_order", 32'(grant_log[k]), 32'(e_grants[k]));
    for (int k = 1; k < 4 && k < grant_cyc.size(); k++)
      checkOutput("t2_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd11);

    // Reset in the middle of a burst, then restart from beat 0.
    req_valid = '0;
    repeat (15) tick();
    done_seen = '0;
    req_addr[0 +: AW] = AW'(300); req_valid = 2'b01;
    tick();
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_gray_req",  32'(gray_req),  32'd0);
    checkOutput("t5_gray_addr", 32'(gray_addr), 32'd0);
    checkOutput("t5_grant",     32'(grant),     32'd0);
    checkOutput("t5_rd_valid",  32'(rd_valid),  32'd0);
    checkOutput("t5_busy",      32'(busy),      32'd0);
    clearCaptures();
    waitDone(0, "t5_done");
    req_valid = '0; done_seen = '0;
    checkOutput("t5_restart_len", 32'(cap_addr.size()), 32'd9);
    if (cap_addr.size() > 0)
      checkOutput("t5_restart_addr", 32'(cap_addr[0]), 32'd300);
    repeat (3) tick();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) applyStimulus();
    reset = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
